// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential 8x8 radix-2 Booth multiplier among NREQ requesters.
// Sequences load plus eight Booth steps, then returns the tagged 16-bit product.
module booth_mult_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_mc,
  input  logic [8*NREQ-1:0]    req_mp,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_start,
  output logic [7:0]           mul_mc,
  output logic [7:0]           mul_mp,
  input  logic [15:0]          mul_prod,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [15:0]          res_prod,
  output logic                 busy
);

  localparam int unsigned OPW   = 8;
  localparam int unsigned CW    = 3;
  localparam int unsigned STEPS = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [IDW-1:0]  rr_ptr, rr_ptr_nxt;
  logic [IDW-1:0]  own_id;
  logic [IDW-1:0]  gnt_idx, hi_idx, lo_idx;
  logic            hi_found, lo_found;
  logic            take;
  logic [OPW-1:0]  sel_mc, sel_mp;

  // First valid requester at or above rr_ptr, else the lowest valid one (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_mc = '0;
    sel_mp = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_mc = req_mc[i*OPW +: OPW];
        sel_mp = req_mp[i*OPW +: OPW];
      end
    end
  end

  // Next-state, counter, pointer and combinational accept.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    req_ready  = '0;
    take       = 1'b0;
    case (state)
      S_IDLE: begin
        if (lo_found && !rst) begin
          take       = 1'b1;
          req_ready  = NREQ'(1) << gnt_idx;
          rr_ptr_nxt = (int'(gnt_idx) == int'(NREQ) - 1) ? '0 : gnt_idx + IDW'(1);
          state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_nxt   = '0;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(STEPS - 1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // Registered datapath controls and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_start <= 1'b0;
      mul_mc    <= '0;
      mul_mp    <= '0;
      own_id    <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_prod  <= '0;
    end else begin
      mul_start <= (state_nxt == S_LOAD);
      busy      <= (state_nxt != S_IDLE);
      res_valid <= (state == S_DONE);
      if (take) begin
        mul_mc <= sel_mc;
        mul_mp <= sel_mp;
        own_id <= gnt_idx;
      end
      if (state == S_DONE) begin
        res_prod <= mul_prod;
        res_id   <= own_id;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural Booth datapath attached.
module tb_booth_mult_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_mc;
  logic [8*NREQ-1:0] req_mp;
  logic [NREQ-1:0]   req_ready;
  logic              mul_start;
  logic [7:0]        mul_mc;
  logic [7:0]        mul_mp;
  logic [15:0]       mul_prod;
  logic              res_valid;
  logic [IDW-1:0]    res_id;
  logic [15:0]       res_prod;
  logic              busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mc(req_mc), .req_mp(req_mp), .req_ready(req_ready),
    .mul_start(mul_start), .mul_mc(mul_mc), .mul_mp(mul_mp), .mul_prod(mul_prod),
    .res_valid(res_valid), .res_id(res_id), .res_prod(res_prod), .busy(busy)
  );

  // Radix-2 Booth datapath: load on mul_start, otherwise one step per edge.
  logic [7:0] dp_a, dp_q, dp_m, dp_sum;
  logic       dp_q1;
  assign mul_prod = {dp_a, dp_q};

  always_comb begin
    case ({dp_q[0], dp_q1})
      2'b01:   dp_sum = dp_a + dp_m;
      2'b10:   dp_sum = dp_a - dp_m;
      default: dp_sum = dp_a;
    endcase
  end

  always @(posedge clk) begin
    if (mul_start) begin
      dp_a  <= 8'h00;
      dp_q  <= mul_mp;
      dp_q1 <= 1'b0;
      dp_m  <= mul_mc;
    end else begin
      {dp_a, dp_q, dp_q1} <= {dp_sum[7], dp_sum, dp_q};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [7:0] mc, input logic [7:0] mp, input logic v);
    req_mc[idx*8 +: 8] = mc;
    req_mp[idx*8 +: 8] = mp;
    req_valid[idx]     = v;
  endtask

  // Waits (bounded) for a grant, checks it, and drops the granted request after the edge.
  task automatic wait_grant(input int exp_idx, input string tag);
    int n = 0;
    #1;
    while (req_ready == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(req_ready), 32'(4'b0001 << exp_idx));
    @(posedge clk);
    #1;
    req_valid[exp_idx] = 1'b0;
  endtask

  task automatic wait_result(input logic [1:0] exp_id, input logic [15:0] exp_prod, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (res_valid !== 1'b1 && n < 40);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_id"},    32'(res_id),    32'(exp_id));
    chk({tag, "_prod"},  32'(res_prod),  32'(exp_prod));
  endtask

  initial begin
    int          starts, busys, first_rv, rvs, rv_seen, last, cyc, n;
    logic [15:0] cap_prod;
    logic [1:0]  cap_id;
    logic [15:0] exp4 [4];

    req_valid = '0;
    req_mc    = '0;
    req_mp    = '0;

    // Reset values, with all requests raised to confirm req_ready stays low.
    #2 rst = 1'b1;
    req_valid = 4'hF;
    #2;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_outs", 32'({mul_start, mul_mc, mul_mp, res_valid, busy}), 32'd0);
    chk("rst_res", 32'({res_id, res_prod}), 32'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single request: grant, strobe widths, latency and product.
    set_req(0, 8'd3, 8'd5, 1'b1);
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    starts = 0; busys = 0; first_rv = 0; rvs = 0; cap_prod = '0; cap_id = '0;
    for (int s = 1; s <= 12; s++) begin
      @(negedge clk);
      if (mul_start) starts++;
      if (busy) busys++;
      if (res_valid) begin
        rvs++;
        if (first_rv == 0) first_rv = s;
        cap_prod = res_prod;
        cap_id   = res_id;
      end
      if (s == 5) begin
        chk("t1_hold_ops", 32'({mul_mc, mul_mp}), 32'h0305);
      end
    end
    chk("t1_start_cycles", 32'(starts), 32'd1);
    chk("t1_busy_cycles", 32'(busys), 32'd10);
    chk("t1_latency", 32'(first_rv), 32'd11);
    chk("t1_valid_cycles", 32'(rvs), 32'd1);
    chk("t1_id", 32'(cap_id), 32'd0);
    chk("t1_prod", 32'(cap_prod), 32'h000F);

    // Signed products.
    set_req(2, 8'hFF, 8'h01, 1'b1);
    wait_grant(2, "t2_gnt");
    wait_result(2'd2, 16'hFFFF, "t2");
    set_req(3, 8'h7F, 8'h80, 1'b1);
    wait_grant(3, "t3_gnt");
    wait_result(2'd3, 16'hC080, "t3");
    set_req(1, 8'hF9, 8'hF7, 1'b1);
    wait_grant(1, "t4_gnt");
    wait_result(2'd1, 16'h003F, "t4");

    // Pointer now 2: requesters 1 and 3 valid, 3 wins; 2 raised during RUN waits.
    set_req(1, 8'h02, 8'h03, 1'b1);
    set_req(3, 8'hFE, 8'h04, 1'b1);
    wait_grant(3, "t5_gnt3");
    repeat (3) @(posedge clk);
    #1 set_req(2, 8'h05, 8'hFD, 1'b1);
    @(negedge clk);
    chk("t5_run_ready", 32'(req_ready), 32'd0);
    chk("t5_run_busy", 32'(busy), 32'd1);
    wait_result(2'd3, 16'hFFF8, "t5_r3");
    chk("t5_same_cycle_ready", 32'(req_ready), 32'h2);
    wait_grant(1, "t5_gnt1");
    wait_result(2'd1, 16'h0006, "t5_r1");
    wait_grant(2, "t5_gnt2");
    wait_result(2'd2, 16'hFFF1, "t5_r2");

    // Reset in the middle of RUN abandons the operation and restarts the pointer.
    set_req(2, 8'h09, 8'h09, 1'b1);
    wait_grant(2, "t6_gnt2");
    repeat (5) @(posedge clk);
    #1;
    set_req(0, 8'h0A, 8'hF6, 1'b1);
    set_req(3, 8'h01, 8'h01, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_rst_outs", 32'({mul_start, mul_mc, mul_mp, res_valid, busy}), 32'd0);
    chk("t6_rst_res", 32'({res_id, res_prod}), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (res_valid) rv_seen++;
    end
    chk("t6_no_valid", 32'(rv_seen), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_grant(0, "t6_gnt0");
    wait_result(2'd0, 16'hFF9C, "t6_r0");
    wait_grant(3, "t6_gnt3");
    wait_result(2'd3, 16'h0001, "t6_r3");

    // All four requesters held valid from reset.
    rst = 1'b1;
    set_req(0, 8'h04, 8'h05, 1'b1);
    set_req(1, 8'hFD, 8'h06, 1'b1);
    set_req(2, 8'h64, 8'h64, 1'b1);
    set_req(3, 8'hCE, 8'h80, 1'b1);
    exp4[0] = 16'h0014;
    exp4[1] = 16'hFFEE;
    exp4[2] = 16'h2710;
    exp4[3] = 16'h1900;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    last = 0;
    cyc  = 0;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        cyc++;
        n++;
      end while (res_valid !== 1'b1 && n < 40);
      chk($sformatf("t7_valid%0d", k), 32'(res_valid), 32'd1);
      chk($sformatf("t7_id%0d", k), 32'(res_id), 32'(k % 4));
      chk($sformatf("t7_prod%0d", k), 32'(res_prod), 32'(exp4[k % 4]));
      if (k > 0) begin
        chk($sformatf("t7_gap%0d", k), 32'(cyc - last), 32'd11);
      end
      last = cyc;
    end
    req_valid = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
